// File: rtl/w_mat_rd_seq.sv
// w_mat_rd_seq: read sequencer for the weight-matrix memory.
// Streams a contiguous range of weight rows (clamped to the memory size) to
// the MAC array over valid/ready. A 2-entry output buffer plus credit-based
// read issue hides the 1-cycle memory latency and sustains one row per cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    command pulse, sampled only in IDLE
//   cfg_first, cfg_num       first row and requested row count
//   busy, done               command in progress / one-cycle completion pulse
//   mem_rd_en, mem_in_c_idx  memory read request (combinational enable)
//   mem_w_vec                memory read data, valid 1 cycle after mem_rd_en
//   w_valid, w_ready         output handshake
//   w_vec, w_idx, w_last     output row, its index, final-row flag
module w_mat_rd_seq #(
  parameter int unsigned IN_C    = 34,
  parameter int unsigned OUT_C   = 32,
  parameter int unsigned W_WIDTH = 8,
  localparam int unsigned IN_C_WIDTH = $clog2(IN_C),
  localparam int unsigned CNT_WIDTH  = $clog2(IN_C + 1),
  localparam int unsigned ROW_WIDTH  = OUT_C * W_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_C_WIDTH-1:0] cfg_first,
  input  logic [CNT_WIDTH-1:0]  cfg_num,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [IN_C_WIDTH-1:0] mem_in_c_idx,
  input  logic [ROW_WIDTH-1:0]  mem_w_vec,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [ROW_WIDTH-1:0]  w_vec,
  output logic [IN_C_WIDTH-1:0] w_idx,
  output logic                  w_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [IN_C_WIDTH-1:0] rd_idx_q;
  logic [CNT_WIDTH-1:0]  rd_left_q;
  logic                  pend_q, pend_last_q;
  logic [IN_C_WIDTH-1:0] pend_idx_q;
  logic                  s_valid, s_last;
  logic [ROW_WIDTH-1:0]  s_vec;
  logic [IN_C_WIDTH-1:0] s_idx;
  logic                  done_q;

  logic [CNT_WIDTH-1:0]  avail_c, eff_c;
  logic [1:0]            occ_c;
  logic                  pop_c, issue_last_c;

  // Effective row count: requested rows clamped to the rows left in memory.
  always_comb begin
    avail_c = '0;
    if (32'(cfg_first) < IN_C) avail_c = CNT_WIDTH'(IN_C - 32'(cfg_first));
    eff_c = (cfg_num < avail_c) ? cfg_num : avail_c;
  end

  // Occupancy after this cycle's pop: buffered rows plus the read whose data
  // is on mem_w_vec now. A new read may go out only if a slot remains for it.
  assign pop_c        = w_valid & w_ready;
  assign occ_c        = 2'(w_valid) + 2'(s_valid) + 2'(pend_q) - 2'(pop_c);
  assign issue_last_c = (rd_left_q == CNT_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and read issue.
  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    case (state_q)
      IDLE:  if (start && eff_c != '0) state_d = RUN;
      RUN: begin
        if (occ_c < 2'd2) begin
          mem_rd_en = 1'b1;
          if (issue_last_c) state_d = DRAIN;
        end
      end
      DRAIN: if (pop_c && w_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command counters, read tracking, completion pulse and output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx_q    <= '0;
      rd_left_q   <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      pend_last_q <= 1'b0;
      s_valid     <= 1'b0;
      s_vec       <= '0;
      s_idx       <= '0;
      s_last      <= 1'b0;
      w_valid     <= 1'b0;
      w_vec       <= '0;
      w_idx       <= '0;
      w_last      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (state_q == IDLE && start) begin
        // Only load the address for a real command so it never goes out of range.
        if (eff_c != '0) rd_idx_q <= cfg_first;
        rd_left_q <= eff_c;
        done_q    <= (eff_c == '0);
      end

      if (mem_rd_en) begin
        rd_left_q <= rd_left_q - CNT_WIDTH'(1);
        if (!issue_last_c) rd_idx_q <= rd_idx_q + IN_C_WIDTH'(1);
      end

      pend_q      <= mem_rd_en;
      pend_idx_q  <= rd_idx_q;
      pend_last_q <= issue_last_c;

      if (state_q == DRAIN && pop_c && w_last) done_q <= 1'b1;

      // Head register feeds the outputs; s_* is the second slot.
      if (pop_c) begin
        if (s_valid) begin
          w_vec   <= s_vec;
          w_idx   <= s_idx;
          w_last  <= s_last;
          s_valid <= pend_q;
          if (pend_q) begin
            s_vec  <= mem_w_vec;
            s_idx  <= pend_idx_q;
            s_last <= pend_last_q;
          end
        end else begin
          w_valid <= pend_q;
          if (pend_q) begin
            w_vec  <= mem_w_vec;
            w_idx  <= pend_idx_q;
            w_last <= pend_last_q;
          end
        end
      end else if (pend_q) begin
        if (!w_valid) begin
          w_valid <= 1'b1;
          w_vec   <= mem_w_vec;
          w_idx   <= pend_idx_q;
          w_last  <= pend_last_q;
        end else begin
          s_valid <= 1'b1;
          s_vec   <= mem_w_vec;
          s_idx   <= pend_idx_q;
          s_last  <= pend_last_q;
        end
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign mem_in_c_idx = rd_idx_q;

endmodule

// File: tb/tb_w_mat_rd_seq.sv
// Testbench for w_mat_rd_seq: table of commands with hand-computed row ranges,
// a behavioural 1-cycle memory, plus hand-written reset-mid-run sequence.
module tb_w_mat_rd_seq;

  localparam int unsigned IN_C  = 34;
  localparam int unsigned OUT_C = 32;
  localparam int unsigned W_W   = 8;
  localparam int unsigned IW    = 6;
  localparam int unsigned CW    = 6;
  localparam int unsigned RW    = OUT_C * W_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] cfg_first;
  logic [CW-1:0] cfg_num;
  logic          busy, done, mem_rd_en;
  logic [IW-1:0] mem_in_c_idx;
  logic [RW-1:0] mem_w_vec = '0;
  logic          w_valid, w_ready;
  logic [RW-1:0] w_vec;
  logic [IW-1:0] w_idx;
  logic          w_last;

  int tests = 0;
  int fails = 0;

  w_mat_rd_seq #(.IN_C(IN_C), .OUT_C(OUT_C), .W_WIDTH(W_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_first(cfg_first), .cfg_num(cfg_num),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_in_c_idx(mem_in_c_idx),
    .mem_w_vec(mem_w_vec), .w_valid(w_valid), .w_ready(w_ready), .w_vec(w_vec),
    .w_idx(w_idx), .w_last(w_last)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] row_pat(input logic [IW-1:0] idx);
    logic [RW-1:0] r;
    for (int k = 0; k < int'(OUT_C); k++) r[k*8 +: 8] = 8'(32'(idx) * 37 + k * 3 + 11);
    return r;
  endfunction

  // Synchronous-read weight memory model.
  always_ff @(posedge clk) if (mem_rd_en) mem_w_vec <= row_pat(mem_in_c_idx);

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int first;
    int num;
    int mode;      // 0: w_ready always 1, 1: pattern 1,0,0,1
    int restart;   // re-pulse start with other cfg while busy
    int exp_rows;
    int exp_first;
  } vec_t;

  task automatic run_cmd(input vec_t v);
    int  k, issued, acc, done_cnt, done_k, last_k, max_out, first_valid_k;
    bit  held, finished;
    logic [RW-1:0] h_vec;
    logic [IW-1:0] h_idx;
    logic          h_last;
    bit   rpat [4];
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    issued = 0; acc = 0; done_cnt = 0; done_k = -1; last_k = -1; max_out = 0;
    first_valid_k = -1; held = 1'b0; finished = 1'b0; k = 0;
    h_vec = '0; h_idx = '0; h_last = 1'b0;

    @(negedge clk);
    start = 1'b1; cfg_first = IW'(v.first); cfg_num = CW'(v.num);
    while (!finished) begin
      @(negedge clk);
      start = 1'b0;
      if (v.restart != 0 && k == 1) begin
        start = 1'b1; cfg_first = 6'd0; cfg_num = 6'd20;
      end
      w_ready = (v.mode == 0) ? 1'b1 : rpat[k % 4];
      #1;
      if (held) begin
        check("hold_valid", RW'(w_valid), RW'(1));
        check("hold_vec", w_vec, h_vec);
        check("hold_idx", RW'(w_idx), RW'(h_idx));
        check("hold_last", RW'(w_last), RW'(h_last));
      end
      if (mem_rd_en) begin
        check("rd_idx", RW'(mem_in_c_idx), RW'(v.exp_first + issued));
        issued++;
      end
      if (done) begin
        done_cnt++;
        done_k = k;
        check("done_time", RW'(k), RW'((v.exp_rows == 0) ? 0 : last_k + 1));
      end
      check("busy", RW'(busy), RW'(v.exp_rows != 0 && done_cnt == 0));
      if (w_valid && w_ready) begin
        if (first_valid_k < 0) begin
          first_valid_k = k;
          if (v.mode == 0) check("first_valid_lat", RW'(k), RW'(2));
        end
        check("w_idx", RW'(w_idx), RW'(v.exp_first + acc));
        check("w_vec", w_vec, row_pat(IW'(v.exp_first + acc)));
        check("w_last", RW'(w_last), RW'(acc == v.exp_rows - 1));
        if (acc == v.exp_rows - 1) last_k = k;
        acc++;
      end
      if (issued - acc > max_out) max_out = issued - acc;
      held  = w_valid && !w_ready;
      h_vec = w_vec; h_idx = w_idx; h_last = w_last;
      if (done_cnt > 0 && k >= done_k + 3) finished = 1'b1;
      if (k >= 300) begin
        check("timeout", RW'(1), RW'(0));
        finished = 1'b1;
      end
      k++;
    end
    check("rows_accepted", RW'(acc), RW'(v.exp_rows));
    check("reads_issued", RW'(issued), RW'(v.exp_rows));
    check("done_count", RW'(done_cnt), RW'(1));
    check("max_outstanding", RW'(max_out > 2), RW'(0));
    w_ready = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    int n;
    vecs[0] = '{first: 0,  num: 34, mode: 0, restart: 0, exp_rows: 34, exp_first: 0};
    vecs[1] = '{first: 30, num: 10, mode: 0, restart: 0, exp_rows: 4,  exp_first: 30};
    vecs[2] = '{first: 5,  num: 0,  mode: 0, restart: 0, exp_rows: 0,  exp_first: 5};
    vecs[3] = '{first: 40, num: 3,  mode: 0, restart: 0, exp_rows: 0,  exp_first: 40};
    vecs[4] = '{first: 0,  num: 8,  mode: 1, restart: 0, exp_rows: 8,  exp_first: 0};
    vecs[5] = '{first: 10, num: 5,  mode: 0, restart: 1, exp_rows: 5,  exp_first: 10};
    vecs[6] = '{first: 33, num: 1,  mode: 1, restart: 0, exp_rows: 1,  exp_first: 33};

    rst = 1'b1; start = 1'b0; cfg_first = '0; cfg_num = '0; w_ready = 1'b0;
    #12;
    check("rst_busy", RW'(busy), RW'(0));
    check("rst_done", RW'(done), RW'(0));
    check("rst_rd_en", RW'(mem_rd_en), RW'(0));
    check("rst_w_valid", RW'(w_valid), RW'(0));
    check("rst_w_vec", w_vec, RW'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Reset in the middle of a long command, then a short command must be clean.
    @(negedge clk);
    start = 1'b1; cfg_first = 6'd0; cfg_num = 6'd34; w_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (w_valid && w_ready) n++;
      if (n < 3) @(negedge clk);
    end
    check("pre_rst_rows", RW'(n), RW'(3));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", RW'(busy), RW'(0));
    check("mid_rst_done", RW'(done), RW'(0));
    check("mid_rst_rd_en", RW'(mem_rd_en), RW'(0));
    check("mid_rst_rd_idx", RW'(mem_in_c_idx), RW'(0));
    check("mid_rst_w_valid", RW'(w_valid), RW'(0));
    check("mid_rst_w_vec", w_vec, RW'(0));
    check("mid_rst_w_idx", RW'(w_idx), RW'(0));
    check("mid_rst_w_last", RW'(w_last), RW'(0));
    @(negedge clk);
    rst = 1'b0; w_ready = 1'b0;
    run_cmd('{first: 2, num: 2, mode: 0, restart: 0, exp_rows: 2, exp_first: 2});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/w_mat_rd_seq.md
Name: w_mat_rd_seq

Overview:
Read sequencer for the weight-matrix memory (w_mat_wrapper: IN_C rows, each OUT_C*W_WIDTH bits, 1-cycle synchronous read). On a start command it streams a contiguous range of weight rows to the graph-conv MAC array over a valid/ready interface. It hides the memory read latency with a 2-entry output buffer, so one row per cycle is sustained under no backpressure. It never issues an out-of-range row index.

Parameters:
IN_C, 34, number of weight rows (input channels)
OUT_C, 32, output channels per row
W_WIDTH, aegnn::W_WIDTH, bits per weight
IN_C_WIDTH, $clog2(IN_C), row index width (derived)
CNT_WIDTH, $clog2(IN_C+1), row count width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  start pulse; sampled only in IDLE
cfg_first  in  IN_C_WIDTH  first row index, latched at start
cfg_num  in  CNT_WIDTH  rows requested, latched at start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last row is accepted
mem_rd_en  out  1  memory read enable
mem_in_c_idx  out  IN_C_WIDTH  memory row address
mem_w_vec  in  OUT_C*W_WIDTH  memory read data, valid 1 cycle after mem_rd_en
w_valid  out  1  output row valid
w_ready  in  1  consumer ready
w_vec  out  OUT_C*W_WIDTH  output row data
w_idx  out  IN_C_WIDTH  row index of w_vec
w_last  out  1  w_vec is the final row of the command

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, mem_rd_en=0, mem_in_c_idx=0, w_valid=0, w_vec=0, w_idx=0, w_last=0; buffer emptied; in-flight read discarded.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 latches first=cfg_first, eff=min(cfg_num, IN_C-cfg_first).
  - cfg_first>=IN_C gives eff=0.
  - eff=0: no reads issued; done pulses the next cycle; busy stays 0; stay IDLE.
  - Otherwise go to RUN, busy=1.
- RUN: issue a read (mem_rd_en=1, mem_in_c_idx=next row) when credits allow.
  - credits = 2 - (rows buffered + reads in flight).
  - Reads are issued in ascending order from first.
  - After the eff-th read is issued, go to DRAIN.
- DRAIN: no reads; wait until every row has been accepted.
- Completion: on the cycle the w_last row is accepted, done pulses the next cycle; busy falls with done; state returns to IDLE.
- Data path: mem_w_vec is captured into the buffer the cycle after the read, tagged with its idx and a last flag (idx == first+eff-1).
- Output handshake:
  - Output is head of a 2-entry FIFO; transfer when w_valid & w_ready.
  - w_vec, w_idx and w_last stay stable while w_valid=1 and w_ready=0.
  - Simultaneous capture and pop is allowed.
  - Buffer never overflows: credits count reads still in flight.
- Throughput: w_ready held high gives 1 row/cycle; the first w_valid appears 2 cycles after start (read issue at start+1, data captured at start+2).
- start while busy: ignored, no effect on the current command.
- mem_in_c_idx never exceeds IN_C-1; mem_rd_en=0 outside RUN.
- w_ready asserted with w_valid=0: no effect.

Test Plan:
- cfg_first=0, cfg_num=34, w_ready=1 -> 34 rows, w_idx 0..33 on consecutive cycles; w_last only on idx 33; done 1 cycle after; mem_in_c_idx never reaches 34.
- cfg_first=30, cfg_num=10 -> truncated to 4 rows (30..33), w_last on 33, done pulses once.
- cfg_first=5, cfg_num=0 and cfg_first=40, cfg_num=3 -> no mem_rd_en, no w_valid, done one cycle after start, busy stays 0.
- cfg_first=0, cfg_num=8, w_ready toggled 1,0,0,1 repeating -> rows 0..7 in order, none lost or duplicated, outputs held stable while stalled, at most 2 buffered plus in-flight.
- rst asserted mid-RUN (after 3 rows) -> all outputs 0 immediately; new start (first=2, num=2) -> rows 2,3 only, no stale data.
- start re-pulsed with different cfg while busy -> original command completes unchanged, exactly one done.
